// File: rtl/gelu_in_requant.sv
// Requantizes signed accumulators into signed 8-bit GELU activations: round-half-up multiply/shift, saturate.
// Optional saturation counter is built only when GELU_REQ_SATCNT_EN is defined.
module gelu_in_requant #(
    parameter int ACC_W   = 32,
    parameter int MULT_W  = 16,
    parameter int SHIFT_W = 6,
    parameter int OUT_W   = 8,
    parameter int SCALE_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [MULT_W-1:0]  cfg_mult,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic [SCALE_W-1:0] cfg_out_scale,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ACC_W-1:0]   in_acc,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_x,
    output logic [SCALE_W-1:0] out_scale,
    output logic               out_last,
    output logic               busy,
    output logic [15:0]        sat_cnt
);
    localparam int PROD_W = ACC_W + MULT_W;
    localparam int SUM_W  = PROD_W + 1;
    localparam logic [SHIFT_W-1:0]      MAX_SHIFT = SHIFT_W'(PROD_W - 1);
    localparam logic signed [SUM_W-1:0] OUT_MAX   = SUM_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] OUT_MIN   = SUM_W'(-(1 << (OUT_W - 1)));

    // Active configuration
    logic [MULT_W-1:0]  r_mult;
    logic [SHIFT_W-1:0] r_shift;
    logic [SCALE_W-1:0] r_scale;

    // Stage 1: product
    logic                     r_s1_valid;
    logic signed [PROD_W-1:0] r_s1_prod;
    logic [SHIFT_W-1:0]       r_s1_shift;
    logic [SCALE_W-1:0]       r_s1_scale;
    logic                     r_s1_last;

    // Stage 2: rounded and shifted value
    logic                     r_s2_valid;
    logic signed [SUM_W-1:0]  r_s2_val;
    logic [SCALE_W-1:0]       r_s2_scale;
    logic                     r_s2_last;

    // Stage 3: output register
    logic                     r_out_valid;
    logic [OUT_W-1:0]         r_out_x;
    logic [SCALE_W-1:0]       r_out_scale;
    logic                     r_out_last;

    logic                     w_adv;
    logic                     w_in_fire;
    logic                     w_busy;
    logic                     w_cfg_take;
    logic [SHIFT_W-1:0]       w_cfg_shift;
    logic signed [PROD_W-1:0] w_acc_ext;
    logic signed [PROD_W-1:0] w_mult_ext;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [SUM_W-1:0]  w_round;
    logic signed [SUM_W-1:0]  w_sum;
    logic signed [SUM_W-1:0]  w_shifted;
    logic                     w_sat_hi;
    logic                     w_sat_lo;
    logic [OUT_W-1:0]         w_clamped;

    // Whole pipeline advances together; a full output that is not taken freezes everything.
    assign w_adv      = !r_out_valid || out_ready;
    assign w_in_fire  = in_valid && w_adv;
    assign w_busy     = r_s1_valid || r_s2_valid || r_out_valid;
    assign w_cfg_take = cfg_load && !w_busy && !w_in_fire;
    assign w_cfg_shift = (cfg_shift > MAX_SHIFT) ? MAX_SHIFT : cfg_shift;

    assign w_acc_ext  = PROD_W'($signed(in_acc));
    assign w_mult_ext = PROD_W'($signed({1'b0, r_mult}));
    assign w_prod     = w_acc_ext * w_mult_ext;

    // One extra bit of headroom so the rounding offset cannot overflow the product range.
    assign w_round   = (r_s1_shift != '0) ? (SUM_W'(1) << (r_s1_shift - 1'b1)) : '0;
    assign w_sum     = $signed({r_s1_prod[PROD_W-1], r_s1_prod}) + w_round;
    assign w_shifted = w_sum >>> r_s1_shift;

    assign w_sat_hi  = r_s2_val > OUT_MAX;
    assign w_sat_lo  = r_s2_val < OUT_MIN;
    assign w_clamped = w_sat_hi ? {1'b0, {(OUT_W-1){1'b1}}} :
                       w_sat_lo ? {1'b1, {(OUT_W-1){1'b0}}} :
                                  r_s2_val[OUT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mult      <= MULT_W'(1);
            r_shift     <= '0;
            r_scale     <= '1;
            r_s1_valid  <= 1'b0;
            r_s1_prod   <= '0;
            r_s1_shift  <= '0;
            r_s1_scale  <= '0;
            r_s1_last   <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s2_val    <= '0;
            r_s2_scale  <= '0;
            r_s2_last   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_x     <= '0;
            r_out_scale <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_cfg_take) begin
                r_mult  <= cfg_mult;
                r_shift <= w_cfg_shift;
                r_scale <= cfg_out_scale;
            end
            if (w_adv) begin
                r_s1_valid  <= in_valid;
                r_s2_valid  <= r_s1_valid;
                r_out_valid <= r_s2_valid;
                if (in_valid) begin
                    r_s1_prod  <= w_prod;
                    r_s1_shift <= r_shift;
                    r_s1_scale <= r_scale;
                    r_s1_last  <= in_last;
                end
                if (r_s1_valid) begin
                    r_s2_val   <= w_shifted;
                    r_s2_scale <= r_s1_scale;
                    r_s2_last  <= r_s1_last;
                end
                if (r_s2_valid) begin
                    r_out_x     <= w_clamped;
                    r_out_scale <= r_s2_scale;
                    r_out_last  <= r_s2_last;
                end
            end
        end
    end

`ifdef GELU_REQ_SATCNT_EN
    logic [15:0] r_sat_cnt;

    always_ff @(posedge clk) begin
        if (rst || w_cfg_take) begin
            r_sat_cnt <= '0;
        end else if (w_adv && r_s2_valid && (w_sat_hi || w_sat_lo) && (r_sat_cnt != 16'hFFFF)) begin
            r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end

    assign sat_cnt = r_sat_cnt;
`else
    assign sat_cnt = '0;
`endif

    assign in_ready  = w_adv;
    assign out_valid = r_out_valid;
    assign out_x     = r_out_x;
    assign out_scale = r_out_scale;
    assign out_last  = r_out_last;
    assign busy      = w_busy;

endmodule

// File: tb/tb_gelu_in_requant.sv
// Bench for gelu_in_requant: directed scenarios plus randomized traffic against an arithmetic reference.
module tb_gelu_in_requant;
`ifdef GELU_REQ_SATCNT_EN
    localparam bit SATCNT_EN = 1'b1;
`else
    localparam bit SATCNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_load;
    logic [15:0] cfg_mult;
    logic [5:0]  cfg_shift;
    logic [2:0]  cfg_out_scale;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_acc;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_x;
    logic [2:0]  out_scale;
    logic        out_last;
    logic        busy;
    logic [15:0] sat_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int x;
        int scale;
        bit last;
    } exp_t;

    exp_t exp_q[$];

    gelu_in_requant dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_mult(cfg_mult),
        .cfg_shift(cfg_shift), .cfg_out_scale(cfg_out_scale),
        .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x),
        .out_scale(out_scale), .out_last(out_last), .busy(busy), .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    // Reference: floor((acc*mult + 2^(s-1)) / 2^s), shift capped at 47.
    function automatic longint ref_round(longint acc, longint mult, int shift);
        longint num, d, q;
        int s;
        s   = (shift > 47) ? 47 : shift;
        d   = longint'(1) << s;
        num = acc * mult + ((s > 0) ? d / 2 : 0);
        q   = num / d;
        if ((num % d) != 0 && num < 0) q = q - 1;
        return q;
    endfunction

    function automatic int ref_clamp(longint r);
        if (r > 127)  return 127;
        if (r < -128) return -128;
        return int'(r);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input int mult, input int shift, input int scale);
        cfg_mult      = 16'(mult);
        cfg_shift     = 6'(shift);
        cfg_out_scale = 3'(scale);
        in_valid      = 1'b0;
        cfg_load      = 1'b1;
        step();
        cfg_load      = 1'b0;
    endtask

    // Sends one beat with out_ready high and reports what came out and after how many edges.
    task automatic run_beat(input int acc, input bit last, input bit with_cfg,
                            output int x, output int sc, output bit lst, output int lat);
        in_valid  = 1'b1;
        in_acc    = acc;
        in_last   = last;
        out_ready = 1'b1;
        cfg_load  = with_cfg;
        step();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        cfg_load  = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
        x   = int'($signed(out_x));
        sc  = int'(out_scale);
        lst = out_last;
        step();
    endtask

    task automatic test_reset();
        int x, sc, lat;
        bit lst;
        rst = 1'b1;
        step();
        step();
        total += 7;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (out_x !== 8'd0)     begin bad++; $display("FAIL reset_out_x: got %0d expected 0", out_x); end
        if (out_scale !== 3'd0) begin bad++; $display("FAIL reset_out_scale: got %0d expected 0", out_scale); end
        if (out_last !== 1'b0)  begin bad++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
        if (sat_cnt !== 16'd0)  begin bad++; $display("FAIL reset_sat_cnt: got %0d expected 0", sat_cnt); end
        if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        rst = 1'b0;
        run_beat(-77, 1'b0, 1'b0, x, sc, lst, lat);
        total += 2;
        if (x !== -77) begin bad++; $display("FAIL reset_cfg_x: got %0d expected -77", x); end
        if (sc !== 7)  begin bad++; $display("FAIL reset_cfg_scale: got %0d expected 7", sc); end
    endtask

    task automatic test_latency();
        int x, sc, lat;
        bit lst;
        load_cfg(16384, 15, 7);
        run_beat(200, 1'b0, 1'b0, x, sc, lst, lat);
        total += 3;
        if (lat !== 3) begin bad++; $display("FAIL latency: got %0d expected 3", lat); end
        if (x !== 100) begin bad++; $display("FAIL latency_x: got %0d expected 100", x); end
        if (sc !== 7)  begin bad++; $display("FAIL latency_scale: got %0d expected 7", sc); end
    endtask

    task automatic test_rounding();
        int accs[4] = '{3, -3, 1, -1};
        int exps[4] = '{2, -1, 1, 0};
        int x, sc, lat;
        bit lst;
        load_cfg(1, 1, 3);
        for (int i = 0; i < 4; i++) begin
            run_beat(accs[i], 1'b0, 1'b0, x, sc, lst, lat);
            total++;
            if (x !== exps[i]) begin
                bad++;
                $display("FAIL round_%0d: got %0d expected %0d", accs[i], x, exps[i]);
            end
        end
    endtask

    task automatic test_saturate();
        int accs[3] = '{1000, -1000, -128};
        int exps[3] = '{127, -128, -128};
        int x, sc, lat, exp_sat;
        bit lst;
        load_cfg(1, 0, 7);
        for (int i = 0; i < 3; i++) begin
            run_beat(accs[i], 1'b0, 1'b0, x, sc, lst, lat);
            total++;
            if (x !== exps[i]) begin
                bad++;
                $display("FAIL sat_%0d: got %0d expected %0d", accs[i], x, exps[i]);
            end
        end
        exp_sat = SATCNT_EN ? 2 : 0;
        total++;
        if (int'(sat_cnt) !== exp_sat) begin
            bad++;
            $display("FAIL sat_cnt: got %0d expected %0d", sat_cnt, exp_sat);
        end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int recv = 0;
        bit held = 1'b0;
        logic [7:0] held_x = '0;
        load_cfg(1, 0, 5);
        for (int k = 0; k < 60 && recv < 10; k++) begin
            out_ready = !(k >= 4 && k <= 8);
            in_valid  = (sent < 10);
            in_acc    = sent;
            in_last   = (sent == 9);
            #1;
            if (out_valid && !out_ready) begin
                total++;
                if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc %0d: got %b expected 0", k, in_ready); end
            end
            if (held) begin
                total++;
                if (out_x !== held_x) begin bad++; $display("FAIL bp_hold cyc %0d: got %0d expected %0d", k, out_x, held_x); end
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                total += 2;
                if (int'($signed(out_x)) !== recv) begin bad++; $display("FAIL bp_order: got %0d expected %0d", $signed(out_x), recv); end
                if (out_last !== (recv == 9)) begin bad++; $display("FAIL bp_last beat %0d: got %b expected %b", recv, out_last, recv == 9); end
                recv++;
            end
            held   = out_valid && !out_ready;
            held_x = out_x;
            step();
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        total++;
        if (recv !== 10) begin bad++; $display("FAIL bp_count: got %0d expected 10", recv); end
    endtask

    task automatic test_cfg_gating();
        int x, sc, lat, n;
        bit lst;
        load_cfg(1, 0, 7);
        in_valid  = 1'b1;
        in_acc    = 5;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        cfg_mult  = 16'd2;
        cfg_load  = 1'b1;
        #1;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL cfg_busy: got %b expected 1", busy); end
        step();
        cfg_load = 1'b0;
        n = 0;
        while (busy && n < 10) begin step(); n++; end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL cfg_drain: got busy %b expected 0", busy); end
        run_beat(5, 1'b0, 1'b0, x, sc, lst, lat);
        total++;
        if (x !== 5) begin bad++; $display("FAIL cfg_ignored_busy: got %0d expected 5", x); end
        load_cfg(2, 0, 7);
        run_beat(5, 1'b0, 1'b0, x, sc, lst, lat);
        total++;
        if (x !== 10) begin bad++; $display("FAIL cfg_honoured: got %0d expected 10", x); end
        cfg_mult = 16'd3;
        run_beat(5, 1'b0, 1'b1, x, sc, lst, lat);
        run_beat(5, 1'b0, 1'b0, x, sc, lst, lat);
        total++;
        if (x !== 10) begin bad++; $display("FAIL cfg_ignored_handshake: got %0d expected 10", x); end
    endtask

    task automatic test_random();
        int seg_mult, seg_shift, seg_scale, acc, exp_sat;
        longint r;
        bit held;
        logic [7:0] held_x;
        exp_t e;
        for (int seg = 0; seg < 4; seg++) begin
            seg_mult  = (seg == 0) ? $urandom_range(1, 8) : $urandom_range(0, 65535);
            seg_shift = (seg == 0) ? $urandom_range(0, 3) : $urandom_range(0, 63);
            seg_scale = $urandom_range(0, 7);
            load_cfg(seg_mult, seg_shift, seg_scale);
            exp_sat = 0;
            held    = 1'b0;
            held_x  = '0;
            for (int cyc = 0; cyc < 140; cyc++) begin
                case ($urandom_range(0, 2))
                    0:       acc = $urandom;
                    1:       acc = $urandom_range(0, 4000) - 2000;
                    default: acc = $urandom_range(0, 400000) - 200000;
                endcase
                in_valid  = (cyc < 120) && ($urandom_range(0, 9) < 7);
                in_acc    = acc;
                in_last   = ($urandom_range(0, 7) == 0);
                out_ready = (cyc >= 120) || ($urandom_range(0, 9) < 7);
                #1;
                total++;
                if (in_ready !== (!out_valid || out_ready)) begin
                    bad++;
                    $display("FAIL rnd_in_ready seg %0d cyc %0d: got %b expected %b", seg, cyc, in_ready, !out_valid || out_ready);
                end
                if (held) begin
                    total++;
                    if (out_valid !== 1'b1 || out_x !== held_x) begin
                        bad++;
                        $display("FAIL rnd_hold seg %0d cyc %0d: got %b/%0d expected 1/%0d", seg, cyc, out_valid, out_x, held_x);
                    end
                end
                if (out_valid && out_ready) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL rnd_extra seg %0d: got beat %0d expected none", seg, $signed(out_x));
                    end else begin
                        e = exp_q.pop_front();
                        if (int'($signed(out_x)) !== e.x || int'(out_scale) !== e.scale || out_last !== e.last) begin
                            bad++;
                            $display("FAIL rnd_beat seg %0d: got x=%0d sc=%0d last=%b expected x=%0d sc=%0d last=%b",
                                     seg, $signed(out_x), out_scale, out_last, e.x, e.scale, e.last);
                        end
                    end
                end
                if (in_valid && in_ready) begin
                    r = ref_round(longint'(acc), longint'(seg_mult), seg_shift);
                    e.x     = ref_clamp(r);
                    e.scale = seg_scale;
                    e.last  = in_last;
                    exp_q.push_back(e);
                    if (r > 127 || r < -128) exp_sat++;
                end
                held   = out_valid && !out_ready;
                held_x = out_x;
                step();
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
            total += 2;
            if (exp_q.size() !== 0) begin
                bad++;
                $display("FAIL rnd_lost seg %0d: got %0d pending expected 0", seg, exp_q.size());
                exp_q.delete();
            end
            if (!SATCNT_EN) exp_sat = 0;
            if (int'(sat_cnt) !== exp_sat) begin
                bad++;
                $display("FAIL rnd_sat_cnt seg %0d: got %0d expected %0d", seg, sat_cnt, exp_sat);
            end
        end
    endtask

    task automatic test_reset_midstream();
        int x, sc, lat;
        bit lst;
        bit stale = 1'b0;
        load_cfg(2, 0, 4);
        out_ready = 1'b1;
        in_acc    = 50;
        in_valid  = 1'b1;
        step();
        step();
        step();
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        total += 5;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_out_valid: got %b expected 0", out_valid); end
        if (busy !== 1'b0)      begin bad++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        if (out_x !== 8'd0)     begin bad++; $display("FAIL rst_mid_out_x: got %0d expected 0", out_x); end
        if (out_scale !== 3'd0) begin bad++; $display("FAIL rst_mid_out_scale: got %0d expected 0", out_scale); end
        if (out_last !== 1'b0)  begin bad++; $display("FAIL rst_mid_out_last: got %b expected 0", out_last); end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid !== 1'b0) stale = 1'b1;
            step();
        end
        total++;
        if (stale !== 1'b0) begin bad++; $display("FAIL rst_mid_stale: got stale beat expected none"); end
        run_beat(5, 1'b1, 1'b0, x, sc, lst, lat);
        total += 3;
        if (x !== 5)     begin bad++; $display("FAIL rst_mid_cfg_x: got %0d expected 5", x); end
        if (sc !== 7)    begin bad++; $display("FAIL rst_mid_cfg_scale: got %0d expected 7", sc); end
        if (lst !== 1'b1) begin bad++; $display("FAIL rst_mid_last: got %b expected 1", lst); end
    endtask

    initial begin
        rst           = 1'b1;
        cfg_load      = 1'b0;
        cfg_mult      = 16'd1;
        cfg_shift     = 6'd0;
        cfg_out_scale = 3'd7;
        in_valid      = 1'b0;
        in_acc        = '0;
        in_last       = 1'b0;
        out_ready     = 1'b0;
        test_reset();
        test_latency();
        test_rounding();
        test_saturate();
        test_backpressure();
        test_cfg_gating();
        test_random();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
